// File: rtl/sram32_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram32_responder_if
//  Purpose  : 32-bit external RAM bus between ram32_controller and the RAM.
//  Revision : 1.0
// ============================================================================
interface sram32_responder_if #(
   parameter int ADDR_W = 20
);
   logic              WE;
   logic [3:0]        BE;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_data_w;
   logic [31:0]       ram_data_r;

   modport master (
      output WE, BE, ram_addr, ram_data_w,
      input  ram_data_r
   );

   modport slave (
      input  WE, BE, ram_addr, ram_data_w,
      output ram_data_r
   );
endinterface
`default_nettype wire

// File: rtl/sram32_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram32_responder
//  Purpose  : Byte-enabled 32-bit RAM with a fixed, pipelined read latency.
//  Revision : 1.0
// ============================================================================
module sram32_responder #(
   parameter int ADDR_W       = 20,
   parameter int DEPTH        = 65536,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   sram32_responder_if.slave     bus
);

   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int STAGES = READ_LATENCY - 1;

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("sram32_responder: READ_LATENCY must be in 1..4");
   end
   if ((DEPTH & (DEPTH - 1)) != 0 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
      $error("sram32_responder: DEPTH must be a power of 2 no larger than 2**ADDR_W");
   end

   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic             rd_issue;
   logic             wr_issue;
   logic             final_valid;
   logic [31:0]      final_data;
   logic [31:0]      data_r;
   logic             unused_addr;

   assign idx         = bus.ram_addr[IDX_W-1:0];
   assign rd_word     = mem[idx];
   assign unused_addr = ^bus.ram_addr;

   // Equality tests resolve X to false, so an unknown WE or BE performs no write.
   always_comb begin
      rd_issue = 1'b0;
      wr_issue = 1'b0;
      if (bus.WE == 1'b1) begin
         if ((^bus.BE) == 1'b0 || (^bus.BE) == 1'b1) begin
            wr_issue = 1'b1;
         end
      end else if (bus.WE == 1'b0) begin
         rd_issue = 1'b1;
      end
   end

   always_ff @(posedge clk) begin : p_mem
      if (wr_issue) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.BE[i]) begin
               mem[idx][8*i +: 8] <= bus.ram_data_w[8*i +: 8];
            end
         end
      end
   end

   // ram_data_r is the last stage, so only READ_LATENCY-1 stages sit before it.
   if (STAGES > 0) begin : g_pipe
      logic [STAGES-1:0] pv;
      logic [31:0]       pd [STAGES];

      always_ff @(posedge clk or negedge rst) begin : p_valid
         if (!rst) begin
            pv <= '0;
         end else begin
            pv[0] <= rd_issue;
            for (int s = 1; s < STAGES; s++) begin
               pv[s] <= pv[s-1];
            end
         end
      end

      always_ff @(posedge clk) begin : p_data
         pd[0] <= rd_word;
         for (int s = 1; s < STAGES; s++) begin
            pd[s] <= pd[s-1];
         end
      end

      assign final_valid = pv[STAGES-1];
      assign final_data  = pd[STAGES-1];
   end else begin : g_direct
      assign final_valid = rd_issue;
      assign final_data  = rd_word;
   end

   always_ff @(posedge clk or negedge rst) begin : p_out
      if (!rst) begin
         data_r <= '0;
      end else if (final_valid) begin
         data_r <= final_data;
      end
   end

   assign bus.ram_data_r = data_r;

`ifndef SYNTHESIS
   a_known_ctrl : assert property (@(posedge clk) disable iff (!rst) !$isunknown({bus.WE, bus.BE}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram32_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram32_responder
//  Purpose  : Directed bench driving four responders (latency 1..4) in lockstep.
//  Revision : 1.0
// ============================================================================
module tb_sram32_responder;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        we    = 1'b1;
   logic [3:0]  be    = 4'h0;
   logic [19:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rd [1:4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar l = 1; l <= 4; l++) begin : g_dut
      sram32_responder_if #(.ADDR_W(20)) bus ();
      assign bus.WE         = we;
      assign bus.BE         = be;
      assign bus.ram_addr   = addr;
      assign bus.ram_data_w = wdata;
      assign rd[l]          = bus.ram_data_r;

      sram32_responder #(
         .ADDR_W       (20),
         .DEPTH        (65536),
         .READ_LATENCY (l)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   // Each access is presented for one rising edge; the task returns on the
   // following falling edge, where outputs are observed.
   task automatic wr(input logic [19:0] a, input logic [31:0] d, input logic [3:0] b);
      we = 1'b1; addr = a; wdata = d; be = b;
      @(negedge clk);
   endtask

   task automatic rd_op(input logic [19:0] a);
      we = 1'b0; addr = a; wdata = '0; be = 4'h0;
      @(negedge clk);
   endtask

   task automatic idle();
      wr(20'h0, 32'h0, 4'h0);
   endtask

   task automatic test_reset();
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'h0) begin
            errors++;
            $display("FAIL reset L=%0d: got %h expected %h", l, rd[l], 32'h0);
         end
      end
   endtask

   task automatic test_full_word();
      logic [31:0] exp;
      wr(20'h00010, 32'hDEADBEEF, 4'hF);
      rd_op(20'h00010);
      for (int j = 0; j < 4; j++) begin
         if (j > 0) idle();
         for (int l = 1; l <= 4; l++) begin
            exp = (j >= l - 1) ? 32'hDEADBEEF : 32'h0;
            checks++;
            if (rd[l] !== exp) begin
               errors++;
               $display("FAIL full_word L=%0d step=%0d: got %h expected %h", l, j, rd[l], exp);
            end
         end
      end
   endtask

   task automatic test_byte_enable();
      wr(20'h5, 32'h11223344, 4'hF);
      wr(20'h5, 32'hAABBCCDD, 4'b0101);
      rd_op(20'h5);
      repeat (3) idle();
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_merge L=%0d: got %h expected %h", l, rd[l], 32'h11BB33DD);
         end
      end
      wr(20'h5, 32'hFFFFFFFF, 4'h0);
      rd_op(20'h5);
      repeat (3) idle();
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_zero L=%0d: got %h expected %h", l, rd[l], 32'h11BB33DD);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seq1 [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      logic [31:0] seq2 [5] = '{32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
      logic [31:0] exp;
      int u;
      for (int a = 0; a < 4; a++) wr(20'(a), 32'hA0 + 32'(a), 4'hF);
      for (int t = 0; t < 8; t++) begin
         if (t < 4) rd_op(20'(t)); else idle();
         for (int l = 1; l <= 4; l++) begin
            u = t - (l - 1);
            exp = (u < 0) ? 32'h11BB33DD : ((u > 3) ? 32'hA3 : seq1[u]);
            checks++;
            if (rd[l] !== exp) begin
               errors++;
               $display("FAIL back_to_back L=%0d t=%0d: got %h expected %h", l, t, rd[l], exp);
            end
         end
      end
      for (int t = 0; t < 9; t++) begin
         case (t)
            0:       rd_op(20'h0);
            1:       rd_op(20'h1);
            2:       wr(20'h20, 32'hCAFEF00D, 4'hF);
            3:       rd_op(20'h2);
            4:       rd_op(20'h3);
            default: idle();
         endcase
         for (int l = 1; l <= 4; l++) begin
            u = t - (l - 1);
            exp = (u < 0 || u > 4) ? 32'hA3 : seq2[u];
            checks++;
            if (rd[l] !== exp) begin
               errors++;
               $display("FAIL interleaved L=%0d t=%0d: got %h expected %h", l, t, rd[l], exp);
            end
         end
      end
   endtask

   task automatic test_aliasing();
      wr(20'h10003, 32'h5, 4'hF);
      rd_op(20'h00003);
      repeat (3) idle();
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'h5) begin
            errors++;
            $display("FAIL alias L=%0d: got %h expected %h", l, rd[l], 32'h5);
         end
      end
   endtask

   task automatic test_write_inflight();
      logic [31:0] exp;
      wr(20'h7, 32'h1, 4'hF);
      rd_op(20'h7);
      for (int l = 1; l <= 4; l++) begin
         exp = (l == 1) ? 32'h1 : 32'h5;
         checks++;
         if (rd[l] !== exp) begin
            errors++;
            $display("FAIL inflight_issue L=%0d: got %h expected %h", l, rd[l], exp);
         end
      end
      wr(20'h7, 32'h2, 4'hF);
      repeat (2) idle();
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'h1) begin
            errors++;
            $display("FAIL inflight_old L=%0d: got %h expected %h", l, rd[l], 32'h1);
         end
      end
      rd_op(20'h7);
      repeat (3) idle();
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'h2) begin
            errors++;
            $display("FAIL inflight_new L=%0d: got %h expected %h", l, rd[l], 32'h2);
         end
      end
   endtask

   task automatic test_reset_inflight();
      rd_op(20'h00010);
      rd_op(20'h00005);
      we = 1'b1; be = 4'h0; addr = '0;
      rst = 1'b0;
      #1;
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'h0) begin
            errors++;
            $display("FAIL reset_async L=%0d: got %h expected %h", l, rd[l], 32'h0);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      for (int j = 0; j < 4; j++) begin
         idle();
         for (int l = 1; l <= 4; l++) begin
            checks++;
            if (rd[l] !== 32'h0) begin
               errors++;
               $display("FAIL reset_flush L=%0d step=%0d: got %h expected %h", l, j, rd[l], 32'h0);
            end
         end
      end
      rd_op(20'h00010);
      repeat (3) idle();
      for (int l = 1; l <= 4; l++) begin
         checks++;
         if (rd[l] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_retain L=%0d: got %h expected %h", l, rd[l], 32'hDEADBEEF);
         end
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b1;
      test_full_word();
      test_byte_enable();
      test_back_to_back();
      test_aliasing();
      test_write_inflight();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
